// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard controller for the pipelined RISC-V core. It sits beside the datapath
// and the main controller and drives every stall, flush and forward select.
//   - N-stage forwarding: the nearest later stage that writes the source register wins.
//   - Load-use stall between E and D.
//   - Branch/jump flush of D and E.
//   - Multi-cycle execute FSM that holds E for MC_LAT cycles (MUL/DIV).
//   - Saturating 32-bit count of cycles in which the front end is stalled.
//
// Parameters
//   AW          register-address width
//   FWD_STAGES  number of stages after E that can forward (0 = M, 1 = W, ...)
//   MC_LAT      total E-occupancy of a multi-cycle op, 1..256
//   FW          width of each forward select (derived)
//
// Ports
//   clk, rst                    clock (rising edge), async active-high reset
//   rs1_d, rs2_d                sources of the instruction in D
//   rs1_e, rs2_e, rd_e          sources/destination of the instruction in E
//   load_e, regwrite_e          E is a load / E writes the register file
//   rd_stage, regwrite_stage    destination and write-enable of each later stage
//   pcsrc_e                     branch or jump taken in E
//   mc_start_e                  E holds a multi-cycle op
//   stall_f, stall_d, stall_e   hold PC / D register / E register
//   flush_d, flush_e, flush_m   bubble into D / E / M on the next edge
//   fwd_a, fwd_b                0 = register file, k+1 = stage k
//   mc_busy, mc_done            FSM in BUSY / release cycle of a multi-cycle op
//   stall_cnt                   saturating count of stalled front-end cycles
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int AW         = 5,
    parameter int FWD_STAGES = 2,
    parameter int MC_LAT     = 4,
    localparam int FW        = $clog2(FWD_STAGES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AW-1:0]              rs1_d,
    input  logic [AW-1:0]              rs2_d,
    input  logic [AW-1:0]              rs1_e,
    input  logic [AW-1:0]              rs2_e,
    input  logic [AW-1:0]              rd_e,
    input  logic                       load_e,
    input  logic                       regwrite_e,
    input  logic [FWD_STAGES*AW-1:0]   rd_stage,
    input  logic [FWD_STAGES-1:0]      regwrite_stage,
    input  logic                       pcsrc_e,
    input  logic                       mc_start_e,
    output logic                       stall_f,
    output logic                       stall_d,
    output logic                       stall_e,
    output logic                       flush_d,
    output logic                       flush_e,
    output logic                       flush_m,
    output logic [FW-1:0]              fwd_a,
    output logic [FW-1:0]              fwd_b,
    output logic                       mc_busy,
    output logic                       mc_done,
    output logic [31:0]                stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Counter load value on entering BUSY: BUSY lasts MC_LAT-1 cycles, the last
    // of which (cnt==0) is the release cycle.
    localparam logic [7:0] MC_INIT = (MC_LAT > 1) ? 8'(MC_LAT - 2) : 8'd0;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic [FW-1:0] fwd_a_raw, fwd_b_raw;
    logic          lw_stall;
    logic          mc_stall;
    logic          mc_done_raw;

    // -------------------------------------------------------------------------
    // Forwarding. Scanning from the farthest stage down to the nearest lets the
    // nearest match overwrite the others, so the lowest k wins. x0 never forwards.
    // -------------------------------------------------------------------------
    // NOTE: every variable assigned in an always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        fwd_a_raw = '0;
        fwd_b_raw = '0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (regwrite_stage[k] && (rs1_e != '0) && (rd_stage[k*AW +: AW] == rs1_e))
                fwd_a_raw = FW'(k + 1);
            if (regwrite_stage[k] && (rs2_e != '0) && (rd_stage[k*AW +: AW] == rs2_e))
                fwd_b_raw = FW'(k + 1);
        end
    end

    // Load-use: the load result is not available until after M, so D must wait.
    assign lw_stall = load_e && regwrite_e && (rd_e != '0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));

    // -------------------------------------------------------------------------
    // Multi-cycle execute FSM: next state and its decoded outputs.
    // mc_start_e is only looked at in IDLE, so a held start never re-triggers
    // inside BUSY; it starts the next op right after the release edge instead.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mc_stall    = 1'b0;
        mc_done_raw = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mc_start_e && (MC_LAT > 1)) begin
                    mc_stall = 1'b1;
                    state_d  = BUSY;
                    cnt_d    = MC_INIT;
                end
            end
            BUSY: begin
                if (cnt_q != 8'd0) begin
                    mc_stall = 1'b1;
                    cnt_d    = cnt_q - 8'd1;
                end else begin
                    mc_done_raw = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stall counter saturates instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_f && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Everything combinational is forced low while rst is high so the
    // pipeline sees no stray stall or flush during reset.
    // mc_stall dominates lw_stall for E: E is being held, so it must not be bubbled.
    // A taken branch together with mc_stall should never happen; if it does,
    // both the flushes and the hold are still driven.
    // -------------------------------------------------------------------------
    assign stall_f   = !rst && (lw_stall || mc_stall);
    assign stall_d   = stall_f;
    assign stall_e   = !rst && mc_stall;
    assign flush_m   = !rst && mc_stall;
    assign flush_e   = !rst && ((lw_stall && !mc_stall) || pcsrc_e);
    assign flush_d   = !rst && pcsrc_e;
    assign fwd_a     = rst ? '0 : fwd_a_raw;
    assign fwd_b     = rst ? '0 : fwd_b_raw;
    assign mc_busy   = !rst && (state_q == BUSY);
    assign mc_done   = !rst && mc_done_raw;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Self-checking bench for pipeline_hazard_ctrl with default parameters
// (AW=5, FWD_STAGES=2, MC_LAT=4). A table of hand-computed vectors covers the
// combinational forwarding / load-use / branch paths; hand-written sequences
// cover reset, the multi-cycle FSM, back-to-back ops and reset mid-BUSY.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int AW = 5;
    localparam int NS = 2;
    localparam int FW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
    logic              load_e, regwrite_e;
    logic [NS*AW-1:0]  rd_stage;
    logic [NS-1:0]     regwrite_stage;
    logic              pcsrc_e, mc_start_e;
    logic              stall_f, stall_d, stall_e;
    logic              flush_d, flush_e, flush_m;
    logic [FW-1:0]     fwd_a, fwd_b;
    logic              mc_busy, mc_done;
    logic [31:0]       stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rs1_d          (rs1_d),
        .rs2_d          (rs2_d),
        .rs1_e          (rs1_e),
        .rs2_e          (rs2_e),
        .rd_e           (rd_e),
        .load_e         (load_e),
        .regwrite_e     (regwrite_e),
        .rd_stage       (rd_stage),
        .regwrite_stage (regwrite_stage),
        .pcsrc_e        (pcsrc_e),
        .mc_start_e     (mc_start_e),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .stall_e        (stall_e),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .flush_m        (flush_m),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .mc_busy        (mc_busy),
        .mc_done        (mc_done),
        .stall_cnt      (stall_cnt)
    );

    // ctl packs {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m}
    typedef struct {
        logic [AW-1:0] r1d, r2d, r1e, r2e, rde;
        logic          ld, rw;
        logic [AW-1:0] rdm, rdw;
        logic [NS-1:0] rws;
        logic          pc;
        logic [5:0]    ctl;
        logic [FW-1:0] fa, fb;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [AW-1:0] r1d, r2d, r1e, r2e, rde,
                       input logic ld, rw,
                       input logic [AW-1:0] rdm, rdw,
                       input logic [NS-1:0] rws,
                       input logic pc,
                       input logic [5:0] ctl,
                       input logic [FW-1:0] fa, fb);
        vec_t v;
        v.r1d = r1d; v.r2d = r2d; v.r1e = r1e; v.r2e = r2e; v.rde = rde;
        v.ld = ld; v.rw = rw; v.rdm = rdm; v.rdw = rdw; v.rws = rws;
        v.pc = pc; v.ctl = ctl; v.fa = fa; v.fb = fb;
        vecs.push_back(v);
    endtask

    task automatic clear_inputs();
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0;
        load_e = 1'b0; regwrite_e = 1'b0;
        rd_stage = '0; regwrite_stage = '0;
        pcsrc_e = 1'b0; mc_start_e = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Checks {stall_f, stall_d, stall_e, flush_m, flush_e, mc_busy, mc_done}
    // in a multi-cycle window with no load-use or branch active.
    task automatic check_mc(input string tag, input int cyc,
                            input logic stl, input logic busy, input logic done);
        check($sformatf("%s cyc%0d {sf,sd,se,fm,fe,busy,done}", tag, cyc),
              {25'd0, stall_f, stall_d, stall_e, flush_m, flush_e, mc_busy, mc_done},
              {25'd0, stl, stl, stl, stl, 1'b0, busy, done});
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();

        // Table: r1d r2d r1e r2e rde ld rw rdm rdw rws pc | ctl fa fb
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 6'b000000, 0, 0); // quiet
        add(0, 0, 5, 0, 0, 0, 0, 5, 5, 2'b11, 0, 6'b000000, 1, 0); // M beats W
        add(0, 0, 5, 0, 0, 0, 0, 5, 5, 2'b10, 0, 6'b000000, 2, 0); // only W writes
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 6'b000000, 0, 0); // x0 never forwards
        add(0, 0, 3, 9, 0, 0, 0, 3, 9, 2'b11, 0, 6'b000000, 1, 2); // a from M, b from W
        add(0, 0, 3, 9, 0, 0, 0, 3, 9, 2'b00, 0, 6'b000000, 0, 0); // no writers
        add(0, 0, 6, 6, 0, 0, 0, 6, 6, 2'b01, 0, 6'b000000, 1, 1); // both from M
        add(0, 7, 0, 0, 7, 1, 1, 0, 0, 2'b00, 0, 6'b110010, 0, 0); // load-use on rs2
        add(0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 6'b000000, 0, 0); // rd_e = x0
        add(4, 0, 0, 0, 4, 1, 0, 0, 0, 2'b00, 0, 6'b000000, 0, 0); // load w/o regwrite
        add(4, 0, 0, 0, 4, 1, 1, 0, 0, 2'b00, 0, 6'b110010, 0, 0); // load-use on rs1
        add(4, 0, 0, 0, 4, 0, 1, 0, 0, 2'b00, 0, 6'b000000, 0, 0); // not a load
        add(4, 5, 0, 0, 6, 1, 1, 0, 0, 2'b00, 0, 6'b000000, 0, 0); // no register match
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 6'b000110, 0, 0); // branch only
        add(0, 7, 0, 0, 7, 1, 1, 0, 0, 2'b00, 1, 6'b110110, 0, 0); // branch + load-use

        // Reset state: outputs forced low even with active inputs.
        pcsrc_e = 1'b1; mc_start_e = 1'b1; load_e = 1'b1; regwrite_e = 1'b1;
        rd_e = 5'd7; rs2_d = 5'd7; rs1_e = 5'd5; rd_stage = {5'd5, 5'd5}; regwrite_stage = 2'b11;
        #2;
        check("reset outputs {sf,sd,se,fd,fe,fm,fa,fb,busy,done}",
              {20'd0, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, fwd_a, fwd_b, mc_busy, mc_done},
              32'd0);
        check("reset stall_cnt", stall_cnt, 32'd0);
        do_reset();

        // Table-driven combinational vectors (FSM stays IDLE).
        foreach (vecs[i]) begin
            rs1_d = vecs[i].r1d; rs2_d = vecs[i].r2d;
            rs1_e = vecs[i].r1e; rs2_e = vecs[i].r2e; rd_e = vecs[i].rde;
            load_e = vecs[i].ld; regwrite_e = vecs[i].rw;
            rd_stage = {vecs[i].rdw, vecs[i].rdm};
            regwrite_stage = vecs[i].rws;
            pcsrc_e = vecs[i].pc;
            #1;
            check($sformatf("vec%0d {sf,sd,se,fd,fe,fm}", i),
                  {26'd0, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m},
                  {26'd0, vecs[i].ctl});
            check($sformatf("vec%0d fwd_a", i), {30'd0, fwd_a}, {30'd0, vecs[i].fa});
            check($sformatf("vec%0d fwd_b", i), {30'd0, fwd_b}, {30'd0, vecs[i].fb});
            @(negedge clk);
        end

        // Single multi-cycle op. In cycle 2 a load-use also appears: E is held,
        // so flush_e must stay 0.
        do_reset();
        mc_start_e = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) begin
                load_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
            end else begin
                load_e = 1'b0; regwrite_e = 1'b0; rd_e = '0; rs2_d = '0;
            end
            #1;
            check_mc("single", c, c <= 3, c >= 2, c == 4);
            @(negedge clk);
        end
        mc_start_e = 1'b0;
        #1;
        check_mc("single", 5, 1'b0, 1'b0, 1'b0);
        check("single stall_cnt", stall_cnt, 32'd3);

        // Back-to-back ops: start held for two full occupancies.
        do_reset();
        mc_start_e = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            #1;
            check_mc("b2b", c, (c % 4) != 0, (c % 4) != 1, (c % 4) == 0);
            @(negedge clk);
        end
        mc_start_e = 1'b0;
        #1;
        check_mc("b2b", 9, 1'b0, 1'b0, 1'b0);
        check("b2b stall_cnt", stall_cnt, 32'd6);

        // Reset in the middle of BUSY aborts the op; a fresh op follows.
        do_reset();
        mc_start_e = 1'b1;
        #1;
        check_mc("abort", 1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check_mc("abort", 2, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check_mc("abort in-reset", 2, 1'b0, 1'b0, 1'b0);
        check("abort in-reset stall_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            check_mc("restart", c, c <= 3, c >= 2, c == 4);
            @(negedge clk);
        end
        mc_start_e = 1'b0;
        #1;
        check_mc("restart", 5, 1'b0, 1'b0, 1'b0);
        check("restart stall_cnt", stall_cnt, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
